// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter controller.
// Imported by the arbiter and the controller top level.
package counter_ctrl_pkg;

  localparam int CNT_W_DEF = 3;
  localparam int N_REQ     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic idx);
    onehot = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the requester not served last wins a tie.
// Purely combinational.
module rr_arbiter2
  import counter_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last,
  output logic [N_REQ-1:0] win,
  output logic             valid
);

  logic pick0;
  logic pick1;

  assign pick0 = req[0] & (~req[1] | last);
  assign pick1 = req[1] & (~req[0] | ~last);
  assign valid = |req;

  always_comb begin
    win = '0;
    unique case (1'b1)
      pick0:   win = 2'b01;
      pick1:   win = 2'b10;
      default: win = '0;
    endcase
  end

endmodule

// File: rtl/counter_ctrl.sv
// Controller and round-robin owner of the shared up-counter.
// Clears, enables and shadow-checks the counter for each granted run.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  input  logic [CNT_W-1:0] ctr_out,
  output logic             ctr_clear,
  output logic             ctr_enable,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             err,
  output logic             busy
);

  state_t           state;
  state_t           state_nx;
  logic             own;
  logic             last;
  logic             mis;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] len_q;
  logic [N_REQ-1:0] arb_win;
  logic             arb_valid;

  rr_arbiter2 u_arb (
    .req   (req),
    .last  (last),
    .win   (arb_win),
    .valid (arb_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    ctr_clear  = 1'b0;
    ctr_enable = 1'b0;
    grant      = '0;
    done       = '0;
    err        = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (arb_valid) state_nx = CLEAR;
      end
      CLEAR: begin
        grant     = onehot(own);
        ctr_clear = 1'b1;
        state_nx  = RUN;
      end
      RUN: begin
        grant      = onehot(own);
        ctr_enable = 1'b1;
        if (cyc == len_q) state_nx = DONE;
      end
      DONE: begin
        done     = onehot(own);
        err      = mis;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shadow count tracks what the counter must show each RUN cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      own   <= 1'b0;
      last  <= 1'b1;
      mis   <= 1'b0;
      cyc   <= '0;
      len_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            own   <= arb_win[1];
            len_q <= arb_win[1] ? len1 : len0;
          end
        end
        CLEAR: begin
          cyc <= '0;
          mis <= 1'b0;
        end
        RUN: begin
          if (ctr_out != cyc) mis <= 1'b1;
          if (cyc != len_q)   cyc <= cyc + CNT_W'(1);
        end
        DONE: last <= own;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: schedule-based model, per-cycle compare,
// plus directed runs with literal expectations.
module tb_counter_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req   = 2'b00;
  logic [2:0] len0  = 3'd0;
  logic [2:0] len1  = 3'd0;
  logic [2:0] ctr_out;
  logic       ctr_clear;
  logic       ctr_enable;
  logic [1:0] grant;
  logic [1:0] done;
  logic       err;
  logic       busy;

  logic [2:0] cnt = 3'd0;
  logic       use_stub = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ctr_clear)       cnt <= 3'd0;
    else if (ctr_enable) cnt <= cnt + 3'd1;
  end

  assign ctr_out = use_stub ? 3'd0 : cnt;

  counter_ctrl #(.CNT_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .len0       (len0),
    .len1       (len1),
    .ctr_out    (ctr_out),
    .ctr_clear  (ctr_clear),
    .ctr_enable (ctr_enable),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  // Model: a grant taken at edge e occupies offsets 0..L+3 after e.
  // Offset 0 clear, 1..L+1 run, L+2 done, L+3 idle.
  bit m_act  = 1'b0;
  int m_off  = 0;
  int m_len  = 0;
  int m_who  = 0;
  int m_last = 1;
  bit m_mis  = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_act  = 1'b0;
      m_off  = 0;
      m_last = 1;
      m_mis  = 1'b0;
    end else begin
      if (m_act && m_off >= 1 && m_off <= m_len + 1 &&
          int'(ctr_out) != m_off - 1)
        m_mis = 1'b1;
      if (m_act && m_off == m_len + 3) m_act = 1'b0;
      else if (m_act) m_off++;
      if (!m_act && req != 2'b00) begin
        if (req == 2'b11) m_who = (m_last == 0) ? 1 : 0;
        else              m_who = req[0] ? 0 : 1;
        m_len  = (m_who == 0) ? int'(len0) : int'(len1);
        m_last = m_who;
        m_act  = 1'b1;
        m_off  = 0;
        m_mis  = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [1:0] oh;
    logic       in_run;
    logic       in_done;
    @(negedge clock);
    oh      = (m_who == 1) ? 2'b10 : 2'b01;
    in_run  = m_act && m_off >= 1 && m_off <= m_len + 1;
    in_done = m_act && m_off == m_len + 2;
    chk("m_clear", {7'd0, ctr_clear}, {7'd0, m_act && m_off == 0});
    chk("m_enable", {7'd0, ctr_enable}, {7'd0, in_run});
    chk("m_grant", {6'd0, grant},
        {6'd0, (m_act && m_off <= m_len + 1) ? oh : 2'b00});
    chk("m_done", {6'd0, done}, {6'd0, in_done ? oh : 2'b00});
    chk("m_err", {7'd0, err}, {7'd0, in_done && m_mis});
    chk("m_busy", {7'd0, busy}, {7'd0, m_act && m_off <= m_len + 2});
  endtask

  task automatic wait_clear(output logic [1:0] g);
    int n = 0;
    while (ctr_clear !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("wait_clear_timeout", {7'd0, ctr_clear}, 8'd1);
    g = grant;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done === 2'b00 && n < 40) begin
      tick();
      n++;
    end
    chk("wait_done_timeout", {7'd0, done != 2'b00}, 8'd1);
  endtask

  logic [1:0] g;
  logic [1:0] exp_g [3];
  logic [2:0] exp_c [3];

  initial begin
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10;
    exp_c[0] = 3'd0;  exp_c[1] = 3'd2;  exp_c[2] = 3'd0;

    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_grant", {6'd0, grant}, 8'd0);
    chk("rst_done", {6'd0, done}, 8'd0);

    // single requester 0, four enabled cycles
    req = 2'b01; len0 = 3'd3;
    tick();
    chk("a_grant", {6'd0, grant}, 8'h01);
    chk("a_clear", {7'd0, ctr_clear}, 8'd1);
    req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("a_enable", {7'd0, ctr_enable}, 8'd1);
      chk("a_ctr", {5'd0, ctr_out}, 8'(k));
    end
    tick();
    chk("a_done", {6'd0, done}, 8'h01);
    chk("a_err", {7'd0, err}, 8'd0);
    tick();
    chk("a_ctr_after", {5'd0, ctr_out}, 8'd4);
    chk("a_idle", {7'd0, busy}, 8'd0);

    // both requesting: alternation, len1=7 run wraps counter
    req = 2'b11; len0 = 3'd1; len1 = 3'd7;
    for (int i = 0; i < 3; i++) begin
      wait_clear(g);
      if (i == 2) req = 2'b00;
      chk("b_grant", {6'd0, g}, {6'd0, exp_g[i]});
      wait_done();
      chk("b_ctr_end", {5'd0, ctr_out}, {5'd0, exp_c[i]});
      chk("b_err", {7'd0, err}, 8'd0);
    end
    repeat (3) tick();

    // stuck counter forces a mismatch
    use_stub = 1'b1;
    req = 2'b10; len1 = 3'd2;
    wait_clear(g);
    req = 2'b00;
    wait_done();
    chk("c_done", {6'd0, done}, 8'h02);
    chk("c_err", {7'd0, err}, 8'd1);
    use_stub = 1'b0;
    repeat (2) tick();

    // reset during RUN cycle 2 abandons the run
    req = 2'b01; len0 = 3'd5;
    wait_clear(g);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    chk("d_grant", {6'd0, grant}, 8'd0);
    chk("d_enable", {7'd0, ctr_enable}, 8'd0);
    chk("d_busy", {7'd0, busy}, 8'd0);
    chk("d_done", {6'd0, done}, 8'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("d_reclear", {7'd0, ctr_clear}, 8'd1);
    chk("d_regrant", {6'd0, grant}, 8'h01);
    req = 2'b00;
    wait_done();
    chk("d_err", {7'd0, err}, 8'd0);
    repeat (2) tick();

    // dropping req mid-run does not abort; len change ignored
    req = 2'b01; len0 = 3'd4;
    wait_clear(g);
    tick();
    req = 2'b00; len0 = 3'd0;
    repeat (5) tick();
    chk("e_done", {6'd0, done}, 8'h01);
    chk("e_err", {7'd0, err}, 8'd0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
